// File: rtl/regfile_wb.sv
// regfile_wb: 8 x 8-bit register file that sits beside the ALU.
// The file has two combinational read ports with write-back bypass, a
// one-stage write-back register, and a registered carry/zero/parity flag set.
// A write is committed to the array one edge after it is accepted. Reads
// forward the in-flight write-back value, so the write is visible to
// dependent reads after a single edge.
module regfile_wb #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [DW-1:0] data_a,
  output logic [DW-1:0] data_b,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          flag_we,
  input  logic          sc_in,
  input  logic          zero_in,
  input  logic          pari_in,
  output logic          sc_out,
  output logic          zero_flag,
  output logic          pari_flag,
  output logic          wb_pending
);

  localparam int DEPTH = 1 << AW;

  // Architectural state
  logic [DW-1:0] regs_q [DEPTH];
  logic [DW-1:0] regs_d [DEPTH];

  // Write-back stage: the write accepted on the previous edge
  logic          wb_valid_q, wb_valid_d;
  logic [AW-1:0] wb_addr_q,  wb_addr_d;
  logic [DW-1:0] wb_data_q,  wb_data_d;

  // ALU flags
  logic carry_q, carry_d;
  logic zero_q,  zero_d;
  logic pari_q,  pari_d;

  // Commit the pending write-back entry into the array
  always_comb begin
    regs_d = regs_q;
    if (wb_valid_q) begin
      regs_d[wb_addr_q] = wb_data_q;
    end else begin
      regs_d = regs_q;
    end
  end

  // Capture a new write request into the write-back stage
  always_comb begin
    wb_valid_d = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    if (wr_en) begin
      wb_valid_d = 1'b1;
      wb_addr_d  = wr_addr;
      wb_data_d  = wr_data;
    end else begin
      wb_valid_d = 1'b0;
    end
  end

  // Load the flags from the ALU when requested, otherwise hold them
  always_comb begin
    carry_d = carry_q;
    zero_d  = zero_q;
    pari_d  = pari_q;
    if (flag_we) begin
      carry_d = sc_in;
      zero_d  = zero_in;
      pari_d  = pari_in;
    end else begin
      carry_d = carry_q;
      zero_d  = zero_q;
      pari_d  = pari_q;
    end
  end

  // State registers; reset wins over any same-cycle write or flag update
  // and drops an uncommitted write-back entry
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      pari_q     <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      pari_q     <= pari_d;
    end
  end

  // Read port A: forward the in-flight write-back value on an address match.
  // The write request of the current cycle is deliberately not forwarded.
  always_comb begin
    data_a = '0;
    if (wb_valid_q && (wb_addr_q == rd_addr_a)) begin
      data_a = wb_data_q;
    end else begin
      data_a = regs_q[rd_addr_a];
    end
  end

  // Read port B: same forwarding rule as port A, evaluated independently
  always_comb begin
    data_b = '0;
    if (wb_valid_q && (wb_addr_q == rd_addr_b)) begin
      data_b = wb_data_q;
    end else begin
      data_b = regs_q[rd_addr_b];
    end
  end

  // Status and flag outputs come straight from registers
  assign sc_out     = carry_q;
  assign zero_flag  = zero_q;
  assign pari_flag  = pari_q;
  assign wb_pending = wb_valid_q;

endmodule

// File: tb/tb_regfile_wb.sv
// tb_regfile_wb: directed test for regfile_wb.
// Each step drives the inputs for one cycle and queues the values expected
// on the outputs in that cycle. Just before the next rising edge, the queue
// is drained and each entry is checked against the DUT outputs.
module tb_regfile_wb;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] rd_addr_a, rd_addr_b, wr_addr;
  logic [7:0] data_a, data_b, wr_data;
  logic       wr_en, flag_we, sc_in, zero_in, pari_in;
  logic       sc_out, zero_flag, pari_flag, wb_pending;

  int errors = 0;
  int checks = 0;

  // Scoreboard: tag, output selector, expected value
  string      tag_q[$];
  int         sel_q[$];
  logic [7:0] exp_q[$];

  localparam int S_A = 0, S_B = 1, S_SC = 2, S_Z = 3, S_P = 4, S_WB = 5;

  regfile_wb #(.DW(8), .AW(3)) dut (
    .clk(clk), .reset(reset),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .data_a(data_a), .data_b(data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .flag_we(flag_we), .sc_in(sc_in), .zero_in(zero_in), .pari_in(pari_in),
    .sc_out(sc_out), .zero_flag(zero_flag), .pari_flag(pari_flag),
    .wb_pending(wb_pending)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] obs(input int sel);
    case (sel)
      S_A:     obs = data_a;
      S_B:     obs = data_b;
      S_SC:    obs = {7'd0, sc_out};
      S_Z:     obs = {7'd0, zero_flag};
      S_P:     obs = {7'd0, pari_flag};
      S_WB:    obs = {7'd0, wb_pending};
      default: obs = 8'hxx;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [7:0] v);
    tag_q.push_back(tag);
    sel_q.push_back(sel);
    exp_q.push_back(v);
  endtask

  task automatic expect_flags(input string tag, input logic sc, input logic z,
                              input logic p);
    expect_val({tag, "_sc"}, S_SC, {7'd0, sc});
    expect_val({tag, "_z"},  S_Z,  {7'd0, z});
    expect_val({tag, "_p"},  S_P,  {7'd0, p});
  endtask

  // Sample away from the rising edge, check the queued expectations,
  // then advance to just after the next rising edge
  task automatic step();
    string      t;
    int         s;
    logic [7:0] e, o;
    @(negedge clk);
    while (tag_q.size() > 0) begin
      t = tag_q.pop_front();
      s = sel_q.pop_front();
      e = exp_q.pop_front();
      o = obs(s);
      checks++;
      assert (o === e) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", t, o, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'h00;
    rd_addr_a = 3'd0; rd_addr_b = 3'd0;
    flag_we = 1'b0; sc_in = 1'b0; zero_in = 1'b0; pari_in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset state: all registers zero on both ports, flags and pending clear
    expect_flags("rst", 1'b0, 1'b0, 1'b0);
    expect_val("rst_wbp", S_WB, 8'h00);
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i);
      rd_addr_b = 3'(7 - i);
      expect_val($sformatf("rst_a%0d", i), S_A, 8'h00);
      expect_val($sformatf("rst_b%0d", 7 - i), S_B, 8'h00);
      step();
    end

    // Single write r3=A5: old value, then bypass, then array
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5; rd_addr_a = 3'd3; rd_addr_b = 3'd0;
    expect_val("w3_req_a", S_A, 8'h00);
    expect_val("w3_req_wbp", S_WB, 8'h00);
    step();
    wr_en = 1'b0; wr_data = 8'h00; rd_addr_b = 3'd3;
    expect_val("w3_byp_a", S_A, 8'hA5);
    expect_val("w3_byp_b", S_B, 8'hA5);
    expect_val("w3_byp_wbp", S_WB, 8'h01);
    step();
    expect_val("w3_arr_a", S_A, 8'hA5);
    expect_val("w3_arr_wbp", S_WB, 8'h00);
    step();

    // Back-to-back writes to r2: 00, 11, 22, 22; r3 stays A5 meanwhile
    rd_addr_b = 3'd2; rd_addr_a = 3'd3;
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h11;
    expect_val("b2b_0", S_B, 8'h00);
    step();
    wr_data = 8'h22;
    expect_val("b2b_1", S_B, 8'h11);
    expect_val("b2b_r3", S_A, 8'hA5);
    step();
    wr_en = 1'b0;
    expect_val("b2b_2", S_B, 8'h22);
    expect_val("b2b_2_wbp", S_WB, 8'h01);
    step();
    expect_val("b2b_3", S_B, 8'h22);
    expect_val("b2b_3_wbp", S_WB, 8'h00);
    step();

    // Streaming writes every cycle to r0..r7; port A watches the previous one
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 8'(8'h40 + i);
      rd_addr_a = 3'(i - 1);
      if (i > 0) begin
        expect_val($sformatf("strm_byp%0d", i - 1), S_A, 8'(8'h40 + i - 1));
        expect_val($sformatf("strm_wbp%0d", i), S_WB, 8'h01);
      end
      step();
    end
    wr_en = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i);
      rd_addr_b = 3'(7 - i);
      expect_val($sformatf("strm_a%0d", i), S_A, 8'(8'h40 + i));
      expect_val($sformatf("strm_b%0d", 7 - i), S_B, 8'(8'h40 + 7 - i));
      step();
    end

    // Write r5=7F, then reset on the next edge: pending write is dropped
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h7F; rd_addr_a = 3'd5; rd_addr_b = 3'd3;
    expect_val("r5_req_a", S_A, 8'h45);
    step();
    wr_en = 1'b0; reset = 1'b1;
    expect_val("r5_byp_a", S_A, 8'h7F);
    expect_val("r5_byp_wbp", S_WB, 8'h01);
    step();
    reset = 1'b0;
    expect_val("r5_rst_a", S_A, 8'h00);
    expect_val("r5_rst_b3", S_B, 8'h00);
    expect_val("r5_rst_wbp", S_WB, 8'h00);
    step();
    expect_val("r5_drop_a", S_A, 8'h00);
    step();

    // Flags: load 1/0/1, then hold against opposite inputs, with a write going on
    flag_we = 1'b1; sc_in = 1'b1; zero_in = 1'b0; pari_in = 1'b1;
    expect_flags("fl_ld", 1'b0, 1'b0, 1'b0);
    step();
    flag_we = 1'b0; sc_in = 1'b0; zero_in = 1'b1; pari_in = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h3C; rd_addr_a = 3'd1;
    expect_flags("fl_q1", 1'b1, 1'b0, 1'b1);
    step();
    wr_en = 1'b0;
    expect_flags("fl_hold", 1'b1, 1'b0, 1'b1);
    step();
    flag_we = 1'b1;
    expect_flags("fl_hold2", 1'b1, 1'b0, 1'b1);
    step();
    flag_we = 1'b0;
    expect_flags("fl_q2", 1'b0, 1'b1, 1'b0);
    expect_val("r1_arr", S_A, 8'h3C);
    step();

    // Reset together with a write and a flag update: reset wins
    reset = 1'b1; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'hFF;
    flag_we = 1'b1; sc_in = 1'b1; zero_in = 1'b1; pari_in = 1'b1;
    step();
    reset = 1'b0; wr_en = 1'b0; flag_we = 1'b0; sc_in = 1'b0; zero_in = 1'b0; pari_in = 1'b0;
    expect_val("sim_r1", S_A, 8'h00);
    expect_val("sim_wbp", S_WB, 8'h00);
    expect_flags("sim", 1'b0, 1'b0, 1'b0);
    step();
    expect_val("sim_r1_late", S_A, 8'h00);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- 8-entry x 8-bit register file with a one-stage write-back register, read bypass and an ALU flag register.
- Sits around the ALU:
  - Read ports A/B drive the ALU inA/inB operands.
  - The write-back port accepts the ALU rslt.
  - The carry flag register feeds the ALU sc_i and captures sc_o, zero and pari.
- Writes commit one cycle after acceptance; reads forward the in-flight value, so back-to-back dependent instructions see correct operands.

Parameters:
DW  8  data width (ALU datapath width)
AW  3  register address width; depth = 2**AW = 8

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high; sampled on rising edge of clk
rd_addr_a  input  AW  read address, operand A
rd_addr_b  input  AW  read address, operand B
data_a  output  DW  operand A (combinational read, to ALU inA)
data_b  output  DW  operand B (combinational read, to ALU inB)
wr_en  input  1  write request; captured into write-back stage this edge
wr_addr  input  AW  write destination
wr_data  input  DW  write data (ALU rslt)
flag_we  input  1  update flag register this edge
sc_in  input  1  ALU carry out (sc_o)
zero_in  input  1  ALU zero
pari_in  input  1  ALU parity
sc_out  output  1  registered carry, to ALU sc_i
zero_flag  output  1  registered zero flag
pari_flag  output  1  registered parity flag
wb_pending  output  1  write-back stage holds an uncommitted write

Behaviour:
- Reset (reset=1 at edge):
  - All 8 registers <= 0.
  - wb_valid <= 0; wb_addr, wb_data <= 0.
  - carry, zero, parity flags <= 0.
  - reset has priority over wr_en and flag_we in the same cycle.
  - A pending write is discarded, not committed.
- Write-back stage:
  - Edge with wr_en=1: wb_valid<=1, wb_addr<=wr_addr, wb_data<=wr_data.
  - Edge with wr_en=0: wb_valid<=0.
  - Every edge where wb_valid=1 (pre-edge): regs[wb_addr] <= wb_data.
  - Write latency to the array is therefore 2 edges after wr_en is presented.
  - Visibility through reads: 1 edge, via bypass.
  - Continuous writes every cycle are sustained with no stall, throughput 1/cycle.
  - Consecutive writes to the same address: the array ends with the later value; the intermediate value is visible through bypass for exactly one cycle.
- Reads (combinational, per port independently):
  - If wb_valid && wb_addr==rd_addr: data = wb_data.
  - Otherwise: data = regs[rd_addr].
  - wr_data presented in the current cycle is NOT forwarded; same-cycle read-after-write returns the older value.
  - Both ports may read the same address.
- wb_pending = wb_valid.
- Flags:
  - Edge with flag_we=1: carry<=sc_in, zero<=zero_in, parity<=pari_in.
  - Otherwise flags hold.
  - sc_out, zero_flag, pari_flag are direct register outputs, 1-cycle latency, no combinational path from inputs.
  - Flag updates are independent of wr_en.
- All address values are valid: no out-of-range case, no hard-wired register.

Test Plan:
- Reset then read all 8 addresses on both ports -> data_a = data_b = 0x00; sc_out/zero_flag/pari_flag/wb_pending = 0.
- wr_en=1, wr_addr=3, wr_data=0xA5 for one cycle; rd_addr_a=3:
  - data_a = 0x00 during the request cycle.
  - data_a = 0xA5 next cycle via bypass, wb_pending=1.
  - 0xA5 from the array thereafter with wb_pending=0.
- Back-to-back writes r2=0x11 then r2=0x22, then idle; rd_addr_b=2 -> data_b sequence 0x00, 0x11, 0x22, 0x22.
- Write r5=0x7F, assert reset in the following cycle -> r5 reads 0x00 afterwards; pending write dropped.
- flag_we=1 with sc_in=1, zero_in=0, pari_in=1, then flag_we=0 with opposite inputs -> sc_out=1, pari_flag=1, zero_flag=0 from the next cycle, held while flag_we=0.
- Simultaneous reset=1, wr_en=1 (r1=0xFF), flag_we=1 (sc_in=1) -> r1=0x00, sc_out=0, wb_pending=0 after the edge.
